// File: rtl/minority_bist.sv
// Self-test sequencer for a 3-input minority gate.
// Sweeps {a,b,c} = 000..111, compares dut_y with a golden minority, and reports the result.
module minority_bist #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [2:0]       vec, vec_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             busy_nxt, done_nxt, pass_nxt, fv_nxt;
  logic [2:0]       fvec_nxt;
  logic             golden;

  // The gate inputs are the registered vector itself, so they stay stable for the whole vector.
  assign {dut_a, dut_b, dut_c} = vec;
  assign golden = ~((vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      vec        <= 3'd0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 3'd0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      fail_valid <= fv_nxt;
      fail_vec   <= fvec_nxt;
    end
  end

  // Next-state and next-output logic; every output is the value it will hold after the edge.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    err_nxt   = err_count;
    fv_nxt    = fail_valid;
    fvec_nxt  = fail_vec;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_APPLY;
          vec_nxt   = 3'd0;
          err_nxt   = '0;
          fv_nxt    = 1'b0;
          fvec_nxt  = 3'd0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      S_APPLY: begin
        cnt_nxt   = '0;
        state_nxt = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_nxt = S_SAMPLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (dut_y != golden) begin
          if (err_count != ERR_MAX) begin
            err_nxt = err_count + ERR_W'(1);
          end
          if (!fail_valid) begin
            fv_nxt   = 1'b1;
            fvec_nxt = vec;
          end
        end
        if (vec == 3'd7) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          pass_nxt  = (err_nxt == '0);
        end else begin
          vec_nxt   = vec + 3'd1;
          state_nxt = S_APPLY;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_minority_bist.sv
// Scoreboard bench for minority_bist: three instances (SETTLE=1/ERR_W=4, SETTLE=1/ERR_W=2, SETTLE=0/ERR_W=4)
// each driving a modelled gate that can be correct, stuck-at-0, stuck-at-1 or inverted (majority).
module tb_minority_bist;

  localparam int SET [3] = '{1, 1, 0};

  typedef struct {
    int inst;
    int done_cyc;
    int err;
    int fv;
    int fvec;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [1:0] mode [3];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int ndone = 0;
  exp_t sbq [$];

  logic a0, b0, c0, y0, busy0, done0, pass0, fv0;
  logic a1, b1, c1, y1, busy1, done1, pass1, fv1;
  logic a2, b2, c2, y2, busy2, done2, pass2, fv2;
  logic [3:0] err0, err2;
  logic [1:0] err1;
  logic [2:0] fvec0, fvec1, fvec2;

  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic       fv_w   [3];
  logic [3:0] err_w  [3];
  logic [2:0] fvec_w [3];
  logic [2:0] vec_w  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate(input logic [1:0] m, input logic a, input logic b, input logic c);
    logic maj;
    maj = (a & b) | (a & c) | (b & c);
    case (m)
      2'd0: gate = ~maj;
      2'd1: gate = 1'b0;
      2'd2: gate = 1'b1;
      default: gate = maj;
    endcase
  endfunction

  assign y0 = gate(mode[0], a0, b0, c0);
  assign y1 = gate(mode[1], a1, b1, c1);
  assign y2 = gate(mode[2], a2, b2, c2);

  minority_bist #(.SETTLE(1), .ERR_W(4)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0));
  minority_bist #(.SETTLE(1), .ERR_W(2)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1));
  minority_bist #(.SETTLE(0), .ERR_W(4)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2));

  assign busy_w[0] = busy0;  assign busy_w[1] = busy1;  assign busy_w[2] = busy2;
  assign done_w[0] = done0;  assign done_w[1] = done1;  assign done_w[2] = done2;
  assign pass_w[0] = pass0;  assign pass_w[1] = pass1;  assign pass_w[2] = pass2;
  assign fv_w[0]   = fv0;    assign fv_w[1]   = fv1;    assign fv_w[2]   = fv2;
  assign err_w[0]  = err0;   assign err_w[1]  = {2'b00, err1}; assign err_w[2] = err2;
  assign fvec_w[0] = fvec0;  assign fvec_w[1] = fvec1;  assign fvec_w[2] = fvec2;
  assign vec_w[0]  = {a0, b0, c0};
  assign vec_w[1]  = {a1, b1, c1};
  assign vec_w[2]  = {a2, b2, c2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse; pass is checked in the following cycle.
  int  busy_cnt [3] = '{0, 0, 0};
  bit  pchk     [3] = '{0, 0, 0};
  int  ppass    [3] = '{0, 0, 0};
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        busy_cnt[i] = 0;
        pchk[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pchk[i]) begin
          chk($sformatf("u%0d pass", i), int'(pass_w[i]), ppass[i]);
          pchk[i] = 1'b0;
        end
        if (busy_w[i]) busy_cnt[i]++;
        if (done_w[i]) begin
          if (sbq.size() == 0) begin
            chk($sformatf("u%0d unexpected done", i), 1, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("u%0d instance", i), i, e.inst);
            chk($sformatf("u%0d done cycle", i), cyc, e.done_cyc);
            chk($sformatf("u%0d err_count", i), int'(err_w[i]), e.err);
            chk($sformatf("u%0d fail_valid", i), int'(fv_w[i]), e.fv);
            chk($sformatf("u%0d fail_vec", i), int'(fvec_w[i]), e.fvec);
            chk($sformatf("u%0d last vec", i), int'(vec_w[i]), 7);
            chk($sformatf("u%0d busy cycles", i), busy_cnt[i], 8 * (SET[i] + 2));
            pchk[i]  = 1'b1;
            ppass[i] = e.pass;
          end
          busy_cnt[i] = 0;
          ndone++;
        end
      end
    end
  end

  task automatic push(input int i, input int done_cyc, input int err, input int fv, input int fvec,
                      input int pass);
    exp_t e;
    e.inst = i; e.done_cyc = done_cyc; e.err = err; e.fv = fv; e.fvec = fvec; e.pass = pass;
    sbq.push_back(e);
  endtask

  task automatic wait_dones(input int target);
    int n;
    n = 0;
    while (ndone < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ndone < target) chk("done timeout", ndone, target);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic run_one(input int i, input logic [1:0] m, input int err, input int fv,
                         input int fvec, input int pass);
    int s, target;
    @(negedge clk);
    target = ndone + 1;
    mode[i] = m;
    s = cyc;
    push(i, s + 1 + 8 * (SET[i] + 2), err, fv, fvec, pass);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    wait_dones(target);
  endtask

  initial begin
    int s, target;
    mode[0] = 2'd0; mode[1] = 2'd0; mode[2] = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d reset busy", i), int'(busy_w[i]), 0);
      chk($sformatf("u%0d reset done", i), int'(done_w[i]), 0);
      chk($sformatf("u%0d reset pass", i), int'(pass_w[i]), 0);
      chk($sformatf("u%0d reset err", i), int'(err_w[i]), 0);
      chk($sformatf("u%0d reset fail_valid", i), int'(fv_w[i]), 0);
      chk($sformatf("u%0d reset fail_vec", i), int'(fvec_w[i]), 0);
      chk($sformatf("u%0d reset vec", i), int'(vec_w[i]), 0);
    end

    // correct gate, stuck-at-0, inverted gate, inverted gate with saturating 2-bit count
    run_one(0, 2'd0, 0, 0, 0, 1);
    run_one(0, 2'd1, 4, 1, 0, 0);
    run_one(0, 2'd3, 8, 1, 0, 0);
    run_one(1, 2'd3, 3, 1, 0, 0);
    // SETTLE=0: stuck-at-1 first fails on 011; then a clean run
    run_one(2, 2'd2, 4, 1, 3, 0);
    run_one(2, 2'd0, 0, 0, 0, 1);

    // Reset during WAIT of vector 011 abandons the run
    @(negedge clk);
    mode[0] = 2'd0;
    s = cyc;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc(s + 11);
    chk("pre-reset vec", int'({a0, b0, c0}), 3);
    chk("pre-reset busy", int'(busy0), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", int'(busy0), 0);
    chk("abort done", int'(done0), 0);
    chk("abort pass", int'(pass0), 0);
    chk("abort err", int'(err0), 0);
    chk("abort fail_valid", int'(fv0), 0);
    chk("abort fail_vec", int'(fvec0), 0);
    chk("abort vec", int'({a0, b0, c0}), 0);
    @(negedge clk);
    reset = 1'b0;
    run_one(0, 2'd0, 0, 0, 0, 1);

    // start pulses while busy and in DONE are ignored
    @(negedge clk);
    target = ndone + 1;
    s = cyc;
    push(0, s + 25, 0, 0, 0, 1);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc(s + 5);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc(s + 25);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_dones(target);
    repeat (30) @(negedge clk);
    chk("no rerun busy", int'(busy0), 0);

    // Held start: back-to-back runs, second APPLY two cycles after the first done
    @(negedge clk);
    target = ndone + 2;
    mode[0] = 2'd2;
    s = cyc;
    push(0, s + 25, 4, 1, 3, 0);
    push(0, s + 51, 4, 1, 3, 0);
    start_v[0] = 1'b1;
    wait_cyc(s + 26);
    chk("held idle gap busy", int'(busy0), 0);
    @(negedge clk);
    chk("held second apply busy", int'(busy0), 1);
    start_v[0] = 1'b0;
    wait_dones(target);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
